// File: rtl/rice_core_pkg.sv
// Shared types, cause constants and helpers for the rice core trap/privilege controller.
package rice_core_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } rice_core_privilege_level;

  localparam int unsigned IRQ_CAUSE_MSI = 3;
  localparam int unsigned IRQ_CAUSE_MTI = 7;
  localparam int unsigned IRQ_CAUSE_MEI = 11;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    TRAP
  } trap_state_e;

  typedef enum logic [1:0] {
    EXCEPTION,
    INTERRUPT,
    MRET
  } trap_kind_e;

  // Interrupt line index to mcause code.
  function automatic int unsigned irq_cause(input int unsigned idx);
    case (idx)
      0:       return IRQ_CAUSE_MEI;
      1:       return IRQ_CAUSE_MSI;
      2:       return IRQ_CAUSE_MTI;
      default: return 13 + idx;
    endcase
  endfunction

  // Reserved mpp encoding 2 returns to machine mode.
  function automatic rice_core_privilege_level mret_privilege(input logic [1:0] mpp);
    return (mpp == 2'd2) ? PRIV_M : rice_core_privilege_level'(mpp);
  endfunction

endpackage

// File: rtl/rice_core_trap_unit_if.sv
// Pipeline flush handshake and PC redirect between the trap unit and the pipeline.
interface rice_core_trap_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush_req;
  logic            flush_ack;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output flush_req,
    output redirect_valid,
    output redirect_pc,
    input  flush_ack
  );

  modport slave (
    input  flush_req,
    input  redirect_valid,
    input  redirect_pc,
    output flush_ack
  );
endinterface

// File: rtl/rice_core_irq_sync.sv
// Per-line interrupt synchroniser with rising-edge latched or level pending capture.
module rice_core_irq_sync #(
  parameter int unsigned     IRQS        = 3,
  parameter logic [IRQS-1:0] IRQ_EDGE    = '0,
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic [IRQS-1:0] i_irq,
  input  logic [IRQS-1:0] i_clr,
  output logic [IRQS-1:0] o_pending
);

  logic [IRQS-1:0] synced;
  logic [IRQS-1:0] prev_q;
  logic [IRQS-1:0] edge_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign synced = i_irq;
  end else begin : g_sync
    logic [IRQS-1:0] chain_q [SYNC_STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      end else if (!i_enable) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      end else begin
        chain_q[0] <= i_irq;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      end
    end

    assign synced = chain_q[SYNC_STAGES-1];
  end

  // A new rising edge wins over the clear from the trap taking that line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      edge_q <= '0;
    end else if (!i_enable) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= synced;
      edge_q <= IRQ_EDGE & ((synced & ~prev_q) | (edge_q & ~i_clr));
    end
  end

  assign o_pending = i_enable ? ((IRQ_EDGE & edge_q) | (~IRQ_EDGE & synced)) : '0;

endmodule

// File: rtl/rice_core_trap_unit.sv
// Trap and privilege controller: selects exception/interrupt/MRET, flushes the pipeline, redirects the PC and strobes CSR updates.
module rice_core_trap_unit
  import rice_core_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     EXCEPTIONS  = 16,
  parameter int unsigned     IRQS        = 3,
  parameter logic [IRQS-1:0] IRQ_EDGE    = '0,
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [EXCEPTIONS-1:0] i_exception,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_tval,
  input  logic                  i_mret,
  input  logic [IRQS-1:0]       i_irq,
  input  logic                  i_mstatus_mie,
  input  logic                  i_mstatus_mpie,
  input  logic [1:0]            i_mstatus_mpp,
  input  logic [IRQS-1:0]       i_mie,
  input  logic [XLEN-3:0]       i_mtvec_base,
  input  logic                  i_mtvec_mode,
  input  logic [XLEN-1:0]       i_mepc,
  rice_core_trap_unit_if.master pipe,
  output logic                  o_csr_set,
  output logic                  o_mie,
  output logic                  o_mpie,
  output logic [1:0]            o_mpp,
  output logic [XLEN-1:0]       o_mepc,
  output logic [XLEN-1:0]       o_mtval,
  output logic                  o_mcause_irq,
  output logic [XLEN-2:0]       o_mcause_code,
  output logic                  o_mepc_set,
  output logic                  o_mtval_set,
  output logic                  o_mcause_set,
  output logic [IRQS-1:0]       o_mip,
  output logic [1:0]            o_privilege
);

  localparam int unsigned CODE_W = XLEN - 1;

  trap_state_e              state_q;
  trap_kind_e               kind_q;
  logic [CODE_W-1:0]        code_q;
  logic [XLEN-1:0]          pc_q;
  logic [XLEN-1:0]          tval_q;
  logic [IRQS-1:0]          line_q;
  rice_core_privilege_level priv_q;
  rice_core_privilege_level trap_priv_q;
  rice_core_privilege_level priv_next_q;

  logic                     flush_req_q;
  logic                     redirect_valid_q;
  logic [XLEN-1:0]          redirect_pc_q;

  logic [IRQS-1:0]          pending;
  logic [IRQS-1:0]          take;
  logic [IRQS-1:0]          irq_clr;
  logic                     glob_ie;
  logic                     ev_valid;
  trap_kind_e               ev_kind;
  logic [CODE_W-1:0]        ev_code;
  logic [IRQS-1:0]          ev_line;
  logic [XLEN-1:0]          trap_target;

  assign irq_clr = (state_q == TRAP && kind_q == INTERRUPT) ? line_q : '0;

  rice_core_irq_sync #(
    .IRQS        (IRQS),
    .IRQ_EDGE    (IRQ_EDGE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_enable  (i_enable),
    .i_irq     (i_irq),
    .i_clr     (irq_clr),
    .o_pending (pending)
  );

  assign glob_ie = i_mstatus_mie || (priv_q != PRIV_M);
  assign take    = pending & i_mie & {IRQS{glob_ie}};

  // Descending scans so the lowest set index is the last one written.
  always_comb begin
    ev_valid = 1'b1;
    ev_kind  = MRET;
    ev_code  = '0;
    ev_line  = '0;
    if (|i_exception) begin
      ev_kind = EXCEPTION;
      for (int unsigned i = EXCEPTIONS; i > 0; i--) begin
        if (i_exception[i-1]) ev_code = CODE_W'(i - 1);
      end
    end else if (|take) begin
      ev_kind = INTERRUPT;
      for (int unsigned k = IRQS; k > 0; k--) begin
        if (take[k-1]) begin
          ev_code = CODE_W'(irq_cause(k - 1));
          ev_line = IRQS'(1) << (k - 1);
        end
      end
    end else begin
      ev_valid = i_mret;
    end
  end

  assign trap_target = {i_mtvec_base, 2'b00}
                     + ((i_mtvec_mode && kind_q == INTERRUPT) ? XLEN'({code_q, 2'b00}) : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= IDLE;
      kind_q           <= EXCEPTION;
      code_q           <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      line_q           <= '0;
      priv_q           <= PRIV_M;
      trap_priv_q      <= PRIV_M;
      priv_next_q      <= PRIV_M;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      o_csr_set        <= 1'b0;
      o_mie            <= 1'b0;
      o_mpie           <= 1'b0;
      o_mpp            <= '0;
      o_mepc           <= '0;
      o_mtval          <= '0;
      o_mcause_irq     <= 1'b0;
      o_mcause_code    <= '0;
      o_mepc_set       <= 1'b0;
      o_mtval_set      <= 1'b0;
      o_mcause_set     <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      o_csr_set        <= 1'b0;
      o_mie            <= 1'b0;
      o_mpie           <= 1'b0;
      o_mpp            <= '0;
      o_mepc           <= '0;
      o_mtval          <= '0;
      o_mcause_irq     <= 1'b0;
      o_mcause_code    <= '0;
      o_mepc_set       <= 1'b0;
      o_mtval_set      <= 1'b0;
      o_mcause_set     <= 1'b0;

      if (!i_enable) begin
        state_q     <= IDLE;
        priv_q      <= PRIV_M;
        flush_req_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ev_valid) begin
              state_q     <= FLUSH;
              flush_req_q <= 1'b1;
              kind_q      <= ev_kind;
              code_q      <= ev_code;
              pc_q        <= i_pc;
              tval_q      <= i_tval;
              line_q      <= ev_line;
              trap_priv_q <= priv_q;
            end
          end
          FLUSH: begin
            if (pipe.flush_ack) begin
              state_q          <= TRAP;
              flush_req_q      <= 1'b0;
              redirect_valid_q <= 1'b1;
              o_csr_set        <= 1'b1;
              if (kind_q == MRET) begin
                o_mie         <= i_mstatus_mpie;
                o_mpie        <= 1'b1;
                o_mpp         <= PRIV_U;
                redirect_pc_q <= i_mepc;
                priv_next_q   <= mret_privilege(i_mstatus_mpp);
              end else begin
                o_mie         <= 1'b0;
                o_mpie        <= i_mstatus_mie;
                o_mpp         <= trap_priv_q;
                o_mepc        <= pc_q;
                o_mtval       <= (kind_q == EXCEPTION) ? tval_q : '0;
                o_mcause_irq  <= (kind_q == INTERRUPT);
                o_mcause_code <= code_q;
                o_mepc_set    <= 1'b1;
                o_mtval_set   <= 1'b1;
                o_mcause_set  <= 1'b1;
                redirect_pc_q <= trap_target;
                priv_next_q   <= PRIV_M;
              end
            end
          end
          TRAP: begin
            state_q <= IDLE;
            priv_q  <= priv_next_q;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pipe.flush_req      = flush_req_q;
  assign pipe.redirect_valid = redirect_valid_q;
  assign pipe.redirect_pc    = redirect_pc_q;
  assign o_mip               = pending;
  assign o_privilege         = priv_q;

endmodule

// File: doc/rice_core_trap_unit.md
# rice_core_trap_unit

Parametrised trap and privilege controller for the rice core, one generation past the exception-only environment block. It adds:
- interrupt lines, either synchronised edge or level, with a fixed priority;
- vectored mtvec;
- mtval capture;
- a flush handshake with the pipeline before redirecting the PC.

It sits between the pipeline and the machine-level CSR block. It owns the privilege level and drives the CSR hardware-set strobes.

## Interface
Parameters:
- XLEN, 32, data/PC width
- EXCEPTIONS, 16, exception vector width; bit i is cause code i
- IRQS, 3, interrupt lines, 1..16
- IRQ_EDGE, '0, IRQS-bit mask; 1 means rising-edge-latched, 0 means level
- SYNC_STAGES, 2, synchroniser depth, 0..3; 0 means no synchroniser

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  block enable; low forces IDLE and M-mode
- i_exception  in  EXCEPTIONS  exception requests from the pipeline, sampled only in IDLE
- i_pc, i_tval  in  XLEN each  faulting PC and trap value, qualified by the event
- i_mret  in  1  MRET retire
- i_irq  in  IRQS  asynchronous interrupt lines
- i_mstatus_mie, i_mstatus_mpie  in  1 each  CSR current values
- i_mstatus_mpp  in  2  CSR current value
- i_mie  in  IRQS  per-line enables from the CSR
- i_mtvec_base  in  XLEN-2  trap vector base
- i_mtvec_mode  in  1  0 means direct, 1 means vectored
- i_mepc  in  XLEN  current mepc
- o_flush_req  out  1  flush request to the pipeline
- i_flush_ack  in  1  pipeline drained
- o_redirect_valid  out  1  one-cycle PC redirect
- o_redirect_pc  out  XLEN  redirect target
- o_csr_set  out  1  one-cycle strobe for all CSR set inputs
- o_mie, o_mpie  out  1 each  new mstatus values
- o_mpp  out  2  new mstatus value
- o_mepc, o_mtval  out  XLEN each  new CSR values
- o_mcause_irq  out  1  new mcause interrupt bit
- o_mcause_code  out  XLEN-1  new mcause code
- o_mepc_set, o_mtval_set, o_mcause_set  out  1 each  qualified strobes; low on MRET
- o_mip  out  IRQS  pending vector
- o_privilege  out  2  current privilege level

## Operation
Privilege:
- Register o_privilege, reset M (3).

Interrupt pending:
- Each line is synchronised through SYNC_STAGES flops.
- Level lines: pending = synchronised value.
- Edge lines: pending sets on a synchronised 0→1 and clears in the TRAP cycle that takes that line.
- Set has priority over clear in the same cycle.

Interrupt take:
- Line k is takeable when pending[k] && i_mie[k] && (i_mstatus_mie || o_privilege != M).
- Priority is lowest index first.
- Cause code for line 0/1/2 is 11/3/7; line k≥3 is 13+k.

Exception selection:
- The lowest set bit of i_exception wins.
- An exception beats an interrupt, and either beats i_mret, when they occur in the same cycle.

FSM:
- IDLE: on an event, latch kind, code, i_pc, i_tval, privilege and line index, then go to FLUSH.
- FLUSH: o_flush_req=1; on i_flush_ack go to TRAP.
- TRAP: drive one-cycle outputs, update privilege, then go to IDLE.
- Events arriving in FLUSH/TRAP are ignored. The latched interrupt is still taken even if the line drops.

TRAP outputs for an exception or interrupt:
- mie=0, mpie=i_mstatus_mie, mpp=latched privilege, privilege→M.
- mepc=latched PC.
- mtval=latched tval for exceptions, 0 for interrupts.
- mcause = {irq, code}.

TRAP outputs for MRET:
- mie=i_mstatus_mpie, mpie=1, mpp=0 (U).
- privilege→i_mstatus_mpp; value 2 is treated as M.
- o_redirect_pc=i_mepc.
- o_mepc_set, o_mtval_set and o_mcause_set are low.

Trap target:
- {i_mtvec_base,2'b00}, plus 4·code when i_mtvec_mode=1 and the trap is an interrupt.
- The sum is truncated to XLEN.

## Timing
- Reset, and i_enable low, give state IDLE, privilege M, all strobes/valids/flush_req 0, pending 0, data outputs 0.
- Reset or disable in FLUSH/TRAP aborts the operation with no strobe.
- Event sampled in cycle N: o_flush_req is high from N+1.
- Ack sampled high in cycle M: TRAP occurs in M+1, with o_redirect_valid=o_csr_set=1 for exactly that cycle. Privilege is visible from M+2.
- Minimum event-to-redirect latency is 2 cycles (ack already high).
- Edge IRQ to pending latency is SYNC_STAGES+1 cycles.
- The earliest next event is sampled in M+2; there is no back-to-back IDLE sampling during TRAP.

## Structure
- Package rice_core_pkg holds:
  - rice_core_privilege_level (U=0, S=1, M=3);
  - interrupt cause constants 3/7/11;
  - trap FSM enum {IDLE, FLUSH, TRAP};
  - trap kind enum {EXCEPTION, INTERRUPT, MRET}.
- Sub-module rice_core_irq_sync: per-line synchroniser, edge detect and pending latch, parametrised by IRQS, IRQ_EDGE and SYNC_STAGES.

## Test plan
- Exception: i_exception=16'h0004, i_pc=32'h100, ack one cycle later. Required: one TRAP cycle with mcause code=2, irq=0; mepc=32'h100; mie=0; redirect={base,00}; privilege M.
- Simultaneous exception and interrupt: exception bit 5 and pending line 0. Required: code 5 is taken; the edge-line pending bit stays set.
- Vectored interrupt: mode=1, base=30'h100 (PC 32'h400), edge line 1 pulse, MIE=1. Required: redirect 32'h40C, mcause irq=1, code 3, mtval=0, then o_mip[1] cleared.
- MRET: i_mstatus_mpp=0, mpie=1, i_mepc=32'h200. Required: redirect 32'h200, mie=1, mpp=0, privilege U, mepc/mcause strobes low.
- Gating and priority: in U-mode with MIE=0, level line 2 is taken. Required: code 7 and mpp=0. Also, lines 0 and 2 pending together give code 11 first.
- Abort: deassert i_rst_n, or drop i_enable, while in FLUSH. Required: o_flush_req=0 next cycle, no strobe, privilege M.
